multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core. Sequences the shared datapath (single memory port,
//  single ALU, IR/MDR/ALUOut/PC+4 regs) through IF/ID/EX/MEM/WB per instruction. Drives mux selects,
//  write strobes, the memory handshake and alu_ctrl_sel for the ALU control decoder. Keeps cycle/retire counters.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles mem_req may wait for mem_ready; 0 = never time out
//  CNT_W        32   width of cycle_cnt / instret_cnt
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high
//  opcode       in   7      IR[6:0], opcodes.v encodings
//  halt_cond    in   1      ECALL halt test (x17==10), valid in ID
//  bcond        in   1      branch compare result from ALU, valid in EX
//  mem_ready    in   1      memory completes the current mem_req this cycle
//  mem_req      out  1      memory access request, held until mem_ready
//  mem_read     out  1      read access
//  mem_write    out  1      write access
//  i_or_d       out  1      address mux: 0 = PC, 1 = ALUOut
//  ir_write     out  1      load IR, MDR-less, and PC+4 register
//  reg_write    out  1      register file write enable
//  wb_sel       out  2      0 = ALUOut, 1 = MDR, 2 = PC+4 reg
//  alu_src_a    out  1      0 = PC, 1 = rs1
//  alu_src_b    out  2      0 = rs2, 1 = imm, 2 = const 4
//  alu_ctrl_sel out  2      0 = force ADD, 1 = funct decode, 2 = branch compare
//  pc_write     out  1      PC update enable
//  pc_src       out  2      0 = PC+4 reg, 1 = PC+imm target adder, 2 = ALUOut (JALR)
//  halted       out  1      core stopped
//  err_code     out  2      0 none, 1 illegal opcode, 2 memory timeout
//  state_o      out  3      current state: IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5
//  cycle_cnt    out  CNT_W  cycles since reset while not halted
//  instret_cnt  out  CNT_W  retired instructions
// BEHAVIOUR
//  - reset=1: next edge gives state IF, counters 0, err_code 0, halted 0, wait counter 0. All strobes are forced 0
//    in any cycle with reset=1, including reset mid-instruction. No access or retire is completed.
//  - Strobes are decoded from state. The exception is ir_write=(IF & mem_ready). The final-state pc_write and
//    reg_write of MEM are qualified by mem_ready. Any strobe not listed below is 0.
//  - IF:  mem_req=mem_read=1, i_or_d=0. Stay until mem_ready. Then ir_write=1 and go to ID.
//  - ID:  decode opcode.
//      ECALL, halt_cond=1: retire, go to HALT.
//      ECALL, halt_cond=0: pc_write, pc_src=0, retire, go to IF.
//      Unknown opcode: go to HALT with err_code=1, no retire.
//      All others: go to EX.
//  - EX:  per opcode.
//      R-type: a=1, b=0, sel=1, go to WB.
//      I-arith: a=1, b=1, sel=1, go to WB.
//      LOAD/STORE: a=1, b=1, sel=0, go to MEM.
//      JALR: a=1, b=1, sel=0, go to WB.
//      BRANCH: a=1, b=0, sel=2, pc_write=1, pc_src=bcond?1:0, retire, go to IF.
//      JAL: pc_write=1, pc_src=1, go to WB.
//  - MEM: mem_req=1, i_or_d=1, mem_read (LOAD) or mem_write (STORE). Hold until mem_ready.
//      LOAD: go to WB.
//      STORE: pc_write, pc_src=0, retire, go to IF.
//  - WB:  reg_write=1.
//      wb_sel = 1 for LOAD, 2 for JAL/JALR, else 0.
//      pc_write=1 except for JAL (PC already written in EX). pc_src=2 for JALR, else 0.
//      retire, go to IF.
//  - Latency with zero-wait memory:
//      R/I-arith 4, LOAD 5, STORE 4, BRANCH 3, JAL 4, JALR 4, ECALL 2 cycles.
//  - Wait counter: increments each IF/MEM cycle with mem_ready=0 and clears on mem_ready or on leaving the state.
//    When it reaches MEM_TIMEOUT (MEM_TIMEOUT!=0) with mem_ready still 0: go to HALT, err_code=2, mem_req drops.
//    mem_ready in that same cycle wins: no timeout.
//  - HALT: absorbing until reset. halted=1, all strobes 0, counters frozen.
//  - cycle_cnt increments every non-reset cycle with state!=HALT. instret_cnt increments on retire cycles.
//    Both wrap modulo 2^CNT_W.
// TESTING
//  - Reset then ADD, mem_ready tied 1: states 0,1,2,4,0. reg_write only in WB. instret=1 and cycle_cnt=4 after WB.
//  - LW with mem_ready low 3 cycles in MEM: mem_req held 4 cycles, then WB wb_sel=1. Total 8 cycles.
//  - BEQ with bcond=1 then BNE with bcond=0: pc_src=1 then 0 in EX. Each retires in 3 cycles.
//  - ECALL halt_cond=1: HALT after ID, halted=1, instret incremented, counters frozen for 10 further cycles.
//  - MEM_TIMEOUT=4, mem_ready=0 in IF: HALT with err_code=2 after the 4th wait cycle. Also cover mem_ready on that cycle: no error.
//  - Opcode 7'h7F: HALT err_code=1. Reset asserted mid-MEM: mem_req=0 that cycle, IF next, counters 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: walks the shared datapath through IF/ID/EX/MEM/WB,
// drives selects, write strobes and the memory handshake, and keeps cycle/retire counters.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             halt_cond,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_ctrl_sel,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [1:0]        err_reg, err_next;
    logic [CNT_W-1:0]  cycle_reg, instret_reg;
    logic              retire;
    logic              mem_phase;
    logic              timeout;

    assign mem_phase = (state_reg == S_IF) || (state_reg == S_MEM);

    // A ready response in the final wait cycle takes priority over the timeout.
    generate
        if (MEM_TIMEOUT != 0) begin : g_timeout
            assign timeout = mem_phase && !mem_ready && (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    assign wait_next = (mem_phase && !mem_ready && !timeout) ? wait_reg + WAIT_W'(1) : '0;

    always_comb begin
        state_next   = state_reg;
        err_next     = err_reg;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_ctrl_sel = 2'd0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;

        case (state_reg)
            S_IF: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                if (timeout) begin
                    state_next = S_HALT;
                    err_next   = ERR_TIMEOUT;
                end else if (mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = S_ID;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_SYSTEM: begin
                        retire = 1'b1;
                        if (halt_cond) begin
                            state_next = S_HALT;
                        end else begin
                            pc_write   = 1'b1;
                            state_next = S_IF;
                        end
                    end
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: state_next = S_EX;
                    default: begin
                        state_next = S_HALT;
                        err_next   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a    = 1'b1;
                        alu_ctrl_sel = 2'd1;
                        state_next   = S_WB;
                    end
                    OP_I: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'd1;
                        alu_ctrl_sel = 2'd1;
                        state_next   = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = 2'd1;
                        state_next = S_MEM;
                    end
                    OP_JALR: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = 2'd1;
                        state_next = S_WB;
                    end
                    OP_BRANCH: begin
                        alu_src_a    = 1'b1;
                        alu_ctrl_sel = 2'd2;
                        pc_write     = 1'b1;
                        pc_src       = bcond ? 2'd1 : 2'd0;
                        retire       = 1'b1;
                        state_next   = S_IF;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd1;
                        state_next = S_WB;
                    end
                    default: state_next = S_IF;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_read  = (opcode == OP_LOAD);
                mem_write = (opcode == OP_STORE);
                if (timeout) begin
                    state_next = S_HALT;
                    err_next   = ERR_TIMEOUT;
                end else if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = S_IF;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (opcode == OP_LOAD) ? 2'd1 :
                             ((opcode == OP_JAL) || (opcode == OP_JALR)) ? 2'd2 : 2'd0;
                // JAL already redirected the PC in EX; only the link value is written here.
                pc_write   = (opcode != OP_JAL);
                pc_src     = (opcode == OP_JALR) ? 2'd2 : 2'd0;
                retire     = 1'b1;
                state_next = S_IF;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IF;
        endcase

        // Reset cancels any access or retire in flight during the same cycle.
        if (reset) begin
            retire       = 1'b0;
            mem_req      = 1'b0;
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            i_or_d       = 1'b0;
            ir_write     = 1'b0;
            reg_write    = 1'b0;
            wb_sel       = 2'd0;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'd0;
            alu_ctrl_sel = 2'd0;
            pc_write     = 1'b0;
            pc_src       = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IF;
            wait_reg    <= '0;
            err_reg     <= ERR_NONE;
            cycle_reg   <= '0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            err_reg   <= err_next;
            if (state_reg != S_HALT) begin
                cycle_reg <= cycle_reg + CNT_W'(1);
            end
            if (retire) begin
                instret_reg <= instret_reg + CNT_W'(1);
            end
        end
    end

    assign halted      = (state_reg == S_HALT);
    assign err_code    = err_reg;
    assign state_o     = state_reg;
    assign cycle_cnt   = cycle_reg;
    assign instret_cnt = instret_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: latency table, directed corner sequences, and randomized
// instructions checked cycle by cycle against a per-instruction script model.
module tb_multicycle_control_fsm;

    localparam int T  = 4;
    localparam int CW = 32;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] opcode;
    logic halt_cond, bcond, mem_ready;
    logic mem_req, mem_read, mem_write, i_or_d, ir_write, reg_write;
    logic [1:0] wb_sel, alu_src_b, alu_ctrl_sel, pc_src, err_code;
    logic alu_src_a, pc_write, halted;
    logic [2:0] state_o;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    multicycle_control_fsm #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .halt_cond(halt_cond), .bcond(bcond),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl_sel(alu_ctrl_sel),
        .pc_write(pc_write), .pc_src(pc_src), .halted(halted), .err_code(err_code),
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    // Packed view of every decoded output: state[21:19], strobes/selects[18:3], halted[2], err[1:0].
    logic [21:0] got;
    assign got = {state_o, mem_req, mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel,
                  alu_src_a, alu_src_b, alu_ctrl_sel, pc_write, pc_src, halted, err_code};

    typedef enum {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_ECALL, C_BAD} cls_t;

    typedef struct {
        logic [6:0]  op;
        logic        hc;
        logic        bc;
        logic        mr;
        logic [21:0] vec;
        logic        ret;
        logic        live;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic       hc;
        logic       bc;
        int         lat;
    } vec_t;

    cyc_t q[$];
    vec_t tbl[9];
    int checks = 0;
    int errors = 0;
    int exp_cyc, exp_ret;
    bit model_halted;
    int model_err;

    task automatic chk(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [21:0] mk(int st, int req, int rd, int wr, int iod, int irw, int rw,
                                       int wbs, int a, int b, int sel, int pcw, int pcs, int h, int err);
        return {st[2:0], req[0], rd[0], wr[0], iod[0], irw[0], rw[0], wbs[1:0],
                a[0], b[1:0], sel[1:0], pcw[0], pcs[1:0], h[0], err[1:0]};
    endfunction

    function automatic cls_t classify(logic [6:0] op);
        case (op)
            OP_R:      return C_R;
            OP_I:      return C_I;
            OP_LOAD:   return C_LD;
            OP_STORE:  return C_ST;
            OP_BRANCH: return C_BR;
            OP_JAL:    return C_JAL;
            OP_JALR:   return C_JALR;
            OP_SYSTEM: return C_ECALL;
            default:   return C_BAD;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic [6:0] op, logic hc, logic bc, logic mr, logic [21:0] v,
                                 logic ret, logic live);
        cyc_t r;
        r.op = op; r.hc = hc; r.bc = bc; r.mr = mr; r.vec = v; r.ret = ret; r.live = live;
        q.push_back(r);
    endfunction

    // A memory phase: 'waits' not-ready cycles then one ready cycle; T consecutive waits end in HALT.
    function automatic bit mem_phase(logic [6:0] op, logic hc, logic bc, int st, int waits,
                                     int rd, int wr, int iod, int irw, int pcw, int ret);
        for (int k = 0; k < waits; k++) begin
            push(op, hc, bc, 1'b0, mk(st, 1, rd, wr, iod, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
            if (k + 1 == T) begin
                model_halted = 1'b1;
                model_err    = 2;
                return 1'b1;
            end
        end
        push(op, hc, bc, 1'b1, mk(st, 1, rd, wr, iod, irw, 0, 0, 0, 0, 0, pcw, 0, 0, 0), 1'(ret), 1'b1);
        return 1'b0;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, derived from its class.
    function automatic void script(logic [6:0] op, logic hc, logic bc, int w_if, int w_mem);
        cls_t c;
        int wbs;
        c = classify(op);
        if (mem_phase(op, hc, bc, 0, w_if, 1, 0, 0, 1, 0, 0)) return;
        if (c == C_ECALL) begin
            push(op, hc, bc, rb(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, hc ? 0 : 1, 0, 0, 0), 1'b1, 1'b1);
            if (hc) model_halted = 1'b1;
            return;
        end
        push(op, hc, bc, rb(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
        if (c == C_BAD) begin
            model_halted = 1'b1;
            model_err    = 1;
            return;
        end
        case (c)
            C_R:         push(op, hc, bc, rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0, 1'b1);
            C_I:         push(op, hc, bc, rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), 1'b0, 1'b1);
            C_BR: begin
                push(op, hc, bc, rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, bc ? 1 : 0, 0, 0), 1'b1, 1'b1);
                return;
            end
            C_JAL:       push(op, hc, bc, rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 1'b0, 1'b1);
            default:     push(op, hc, bc, rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1);
        endcase
        if (c == C_LD || c == C_ST) begin
            if (mem_phase(op, hc, bc, 3, w_mem, c == C_LD, c == C_ST, 1, 0, c == C_ST, c == C_ST)) return;
            if (c == C_ST) return;
        end
        wbs = (c == C_LD) ? 1 : (c == C_JAL || c == C_JALR) ? 2 : 0;
        push(op, hc, bc, rb(), mk(4, 0, 0, 0, 0, 0, 1, wbs, 0, 0, 0, (c == C_JAL) ? 0 : 1,
                                  (c == C_JALR) ? 2 : 0, 0, 0), 1'b1, 1'b1);
    endfunction

    function automatic void halt_tail(int n);
        if (!model_halted) return;
        for (int k = 0; k < n; k++) begin
            push(7'($urandom), rb(), rb(), rb(), mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, model_err),
                 1'b0, 1'b0);
        end
    endfunction

    function automatic void model_clear();
        q.delete();
        exp_cyc = 0;
        exp_ret = 0;
        model_halted = 1'b0;
        model_err = 0;
    endfunction

    task automatic run_queue(string tag, int max_cycles);
        cyc_t r;
        int n;
        n = 0;
        while (q.size() > 0 && n < max_cycles) begin
            r = q.pop_front();
            reset = 1'b0; opcode = r.op; halt_cond = r.hc; bcond = r.bc; mem_ready = r.mr;
            #1;
            chk($sformatf("%s[%0d] outputs", tag, n), 64'(got), 64'(r.vec));
            chk($sformatf("%s[%0d] cycle_cnt", tag, n), 64'(cycle_cnt), 64'(exp_cyc));
            chk($sformatf("%s[%0d] instret_cnt", tag, n), 64'(instret_cnt), 64'(exp_ret));
            if (r.live) exp_cyc++;
            if (r.ret) exp_ret++;
            n++;
            @(posedge clk); #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; opcode = 7'($urandom); halt_cond = rb(); bcond = rb(); mem_ready = 1'b1;
        #1;
        chk("reset strobes", 64'(got[18:3]), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [6:0] ops [8];
        logic [6:0] bad_ops [3];
        logic [CW-1:0] c0, r0;
        logic [6:0] op;
        logic hc, bc;
        int n, w_if, w_mem;

        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM};
        bad_ops = '{7'h7F, 7'h00, 7'h5B};
        tbl[0] = '{OP_R,      1'b0, 1'b0, 4};
        tbl[1] = '{OP_I,      1'b0, 1'b0, 4};
        tbl[2] = '{OP_LOAD,   1'b0, 1'b0, 5};
        tbl[3] = '{OP_STORE,  1'b0, 1'b0, 4};
        tbl[4] = '{OP_BRANCH, 1'b0, 1'b1, 3};
        tbl[5] = '{OP_BRANCH, 1'b0, 1'b0, 3};
        tbl[6] = '{OP_JAL,    1'b0, 1'b0, 4};
        tbl[7] = '{OP_JALR,   1'b0, 1'b0, 4};
        tbl[8] = '{OP_SYSTEM, 1'b0, 1'b0, 2};

        do_reset();
        chk("reset state", 64'(state_o), 64'd0);
        chk("reset cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("reset err_code", 64'(err_code), 64'd0);

        // Zero-wait latency table: each instruction returns to IF after lat cycles and retires once.
        for (int i = 0; i < 9; i++) begin
            opcode = tbl[i].op; halt_cond = tbl[i].hc; bcond = tbl[i].bc; mem_ready = 1'b1;
            c0 = cycle_cnt; r0 = instret_cnt; n = 0;
            do begin
                @(posedge clk); #2;
                n++;
            end while (state_o != 3'd0 && n < 20);
            chk($sformatf("tbl[%0d] latency", i), 64'(n), 64'(tbl[i].lat));
            chk($sformatf("tbl[%0d] retired", i), 64'(instret_cnt - r0), 64'd1);
            chk($sformatf("tbl[%0d] cycles", i), 64'(cycle_cnt - c0), 64'(tbl[i].lat));
            $display("table %0d op=%h latency=%0d", i, tbl[i].op, n);
        end

        do_reset();
        script(OP_R, 0, 0, 0, 0);       run_queue("add", 100);
        script(OP_LOAD, 0, 0, 0, 3);    run_queue("lw_wait3", 100);
        script(OP_BRANCH, 0, 1, 0, 0);  run_queue("beq_taken", 100);
        script(OP_BRANCH, 0, 0, 0, 0);  run_queue("bne_not_taken", 100);
        script(OP_SYSTEM, 1, 0, 0, 0);  halt_tail(10); run_queue("ecall_halt", 100);
        chk("ecall halted", 64'(halted), 64'd1);

        do_reset();
        script(OP_R, 0, 0, T, 0);       halt_tail(3); run_queue("if_timeout", 100);
        do_reset();
        script(OP_R, 0, 0, T - 1, 0);   run_queue("if_ready_last", 100);
        script(OP_STORE, 0, 0, 0, T);   halt_tail(3); run_queue("mem_timeout", 100);
        do_reset();
        script(7'h7F, 0, 0, 0, 0);      halt_tail(3); run_queue("illegal", 100);

        // Reset in the second MEM cycle of a load that is still waiting.
        do_reset();
        script(OP_LOAD, 0, 0, 0, 3);    run_queue("rst_mid_mem", 4);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rst_mid_mem state", 64'(state_o), 64'd3);
        chk("rst_mid_mem strobes", 64'(got[18:3]), 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        model_clear();
        script(OP_R, 0, 0, 0, 0);       run_queue("after_rst", 100);

        for (int t = 0; t < 150; t++) begin
            op = ($urandom_range(0, 19) == 0) ? bad_ops[$urandom_range(0, 2)] : ops[$urandom_range(0, 7)];
            hc = ($urandom_range(0, 3) == 0);
            bc = rb();
            w_if  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2);
            w_mem = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2);
            script(op, hc, bc, w_if, w_mem);
            halt_tail(3);
            $display("txn %0d op=%h hc=%0d bc=%0d w_if=%0d w_mem=%0d halts=%0d err=%0d",
                     t, op, hc, bc, w_if, w_mem, model_halted, model_err);
            run_queue($sformatf("rand%0d", t), 100);
            if (model_halted) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
